// File: rtl/int2float_pkg.sv
// Shared constants and elaboration-time helpers for the int2float converter.
package int2float_pkg;

    localparam int unsigned RND_TRUNC = 0;
    localparam int unsigned RND_RNE   = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Internal exponent must hold IN_W-MAN_W+1: the top exponent plus a rounding carry.
    function automatic int unsigned exp_width(input int unsigned in_w, input int unsigned man_w);
        return clog2(in_w - man_w + 2);
    endfunction

endpackage

// File: rtl/int2float_lzc.sv
// Leading-one detector: index of the most significant set bit, plus an all-zero flag.
module int2float_lzc import int2float_pkg::*; #(
    parameter int unsigned W = 11,
    localparam int unsigned PW = (clog2(W) > 0) ? clog2(W) : 1
) (
    input  logic [W-1:0]  data_i,
    output logic [PW-1:0] pos_o,
    output logic          zero_o
);

    always_comb begin
        pos_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (data_i[i]) pos_o = PW'(i);
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/int2float_pipe.sv
// Three-stage integer-to-minifloat converter with valid/ready flow control.
// S1: magnitude + leading one, S2: normalise, S3: round, saturate and present.
module int2float_pipe import int2float_pkg::*; #(
    parameter int unsigned IN_W       = 11,
    parameter int unsigned EXP_W      = 4,
    parameter int unsigned MAN_W      = 3,
    parameter bit          SIGNED     = 1'b0,
    parameter int unsigned ROUND_MODE = RND_TRUNC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man,
    output logic             out_inexact,
    output logic             out_ovf
);

    localparam int unsigned PosW    = (clog2(IN_W) > 0) ? clog2(IN_W) : 1;
    localparam int unsigned ExpIntW = exp_width(IN_W, MAN_W);
    localparam int unsigned ExpMax  = (32'd1 << EXP_W) - 1;

    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_load, s2_load, s3_load;

    // A stage loads when empty or when its word is leaving this cycle.
    assign s3_load  = !s3_valid_q || out_ready;
    assign s2_load  = !s2_valid_q || s3_load;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    logic            s1_sign_d, s1_sign_q;
    logic [IN_W-1:0] s1_mag_d, s1_mag_q;
    logic [PosW-1:0] s1_pos_d, s1_pos_q;
    logic            s1_zero_d, s1_zero_q;

    // The most negative input negates to 2^(IN_W-1), still representable unsigned.
    assign s1_sign_d = SIGNED && in_data[IN_W-1];
    assign s1_mag_d  = s1_sign_d ? -in_data : in_data;

    int2float_lzc #(
        .W(IN_W)
    ) u_lzc (
        .data_i(s1_mag_d),
        .pos_o (s1_pos_d),
        .zero_o(s1_zero_d)
    );

    logic               s2_sign_q;
    logic [ExpIntW-1:0] s2_exp_d, s2_exp_q;
    logic [MAN_W-1:0]   s2_man_d, s2_man_q;
    logic               s2_guard_d, s2_guard_q;
    logic               s2_sticky_d, s2_sticky_q;
    logic [IN_W:0]      norm;
    logic [PosW-1:0]    shamt;

    // norm carries one spare zero LSB so the sticky slice exists even at IN_W == MAN_W+2.
    always_comb begin
        shamt       = PosW'(IN_W - 1) - s1_pos_q;
        norm        = {s1_mag_q, 1'b0} << shamt;
        s2_exp_d    = '0;
        s2_man_d    = s1_mag_q[MAN_W-1:0];
        s2_guard_d  = 1'b0;
        s2_sticky_d = 1'b0;
        if (!s1_zero_q && (32'(s1_pos_q) >= MAN_W)) begin
            s2_exp_d    = ExpIntW'(32'(s1_pos_q) - MAN_W + 1);
            s2_man_d    = norm[IN_W-1 -: MAN_W];
            s2_guard_d  = norm[IN_W-1-MAN_W];
            s2_sticky_d = |norm[IN_W-2-MAN_W:0];
        end
    end

    logic               inc;
    logic [MAN_W:0]     man_sum;
    logic [ExpIntW-1:0] exp_rnd;
    logic               ovf;
    logic [EXP_W-1:0]   out_exp_d, out_exp_q;
    logic [MAN_W-1:0]   out_man_d, out_man_q;
    logic               out_inexact_d, out_inexact_q;
    logic               out_ovf_d, out_ovf_q;
    logic               out_sign_q;

    always_comb begin
        inc           = (ROUND_MODE == RND_RNE) && s2_guard_q && (s2_sticky_q || s2_man_q[0]);
        man_sum       = {1'b0, s2_man_q} + (MAN_W + 1)'(inc);
        // A mantissa carry leaves the field at zero and bumps the exponent.
        exp_rnd       = s2_exp_q + ExpIntW'(man_sum[MAN_W]);
        ovf           = 32'(exp_rnd) > ExpMax;
        out_exp_d     = ovf ? '1 : EXP_W'(exp_rnd);
        out_man_d     = ovf ? '1 : man_sum[MAN_W-1:0];
        out_inexact_d = s2_guard_q | s2_sticky_q;
        out_ovf_d     = ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_mag_q      <= '0;
            s1_pos_q      <= '0;
            s1_zero_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_exp_q      <= '0;
            s2_man_q      <= '0;
            s2_guard_q    <= 1'b0;
            s2_sticky_q   <= 1'b0;
            s3_valid_q    <= 1'b0;
            out_sign_q    <= 1'b0;
            out_exp_q     <= '0;
            out_man_q     <= '0;
            out_inexact_q <= 1'b0;
            out_ovf_q     <= 1'b0;
        end else begin
            if (s1_load) s1_valid_q <= in_valid;
            if (s1_load && in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
                s1_pos_q  <= s1_pos_d;
                s1_zero_q <= s1_zero_d;
            end
            if (s2_load) s2_valid_q <= s1_valid_q;
            if (s2_load && s1_valid_q) begin
                s2_sign_q   <= s1_sign_q;
                s2_exp_q    <= s2_exp_d;
                s2_man_q    <= s2_man_d;
                s2_guard_q  <= s2_guard_d;
                s2_sticky_q <= s2_sticky_d;
            end
            if (s3_load) s3_valid_q <= s2_valid_q;
            if (s3_load && s2_valid_q) begin
                out_sign_q    <= s2_sign_q;
                out_exp_q     <= out_exp_d;
                out_man_q     <= out_man_d;
                out_inexact_q <= out_inexact_d;
                out_ovf_q     <= out_ovf_d;
            end
        end
    end

    assign out_valid   = s3_valid_q;
    assign out_sign    = out_sign_q;
    assign out_exp     = out_exp_q;
    assign out_man     = out_man_q;
    assign out_inexact = out_inexact_q;
    assign out_ovf     = out_ovf_q;

endmodule

// File: tb/tb_int2float_pipe.sv
// Bench for int2float_pipe: four configurations share one stream, scored against a value model.
module tb_int2float_pipe;
    import int2float_pkg::*;

    typedef struct packed {
        logic       s;
        logic [3:0] e;
        logic [2:0] m;
        logic       ix;
        logic       ov;
    } res_t;

    typedef struct {
        logic [10:0] d;
        int          c;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic       rdy [4];
    logic       vld [4];
    logic       sg  [4];
    logic [3:0] ex  [3];
    logic [2:0] ex3;
    logic [2:0] mn  [4];
    logic       ix  [4];
    logic       ov  [4];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    popped = 0;
    bit    acc;
    bit    lat_chk = 1'b0;
    item_t sbq [$];

    always #5 clk = ~clk;

    // u0: RNE, u1: truncate, u2: signed RNE, u3: EXP_W=3 truncate
    int2float_pipe #(.ROUND_MODE(RND_RNE)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .out_valid(vld[0]), .out_ready(out_ready), .out_sign(sg[0]), .out_exp(ex[0]),
        .out_man(mn[0]), .out_inexact(ix[0]), .out_ovf(ov[0])
    );
    int2float_pipe u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .out_valid(vld[1]), .out_ready(out_ready), .out_sign(sg[1]), .out_exp(ex[1]),
        .out_man(mn[1]), .out_inexact(ix[1]), .out_ovf(ov[1])
    );
    int2float_pipe #(.SIGNED(1'b1), .ROUND_MODE(RND_RNE)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data),
        .out_valid(vld[2]), .out_ready(out_ready), .out_sign(sg[2]), .out_exp(ex[2]),
        .out_man(mn[2]), .out_inexact(ix[2]), .out_ovf(ov[2])
    );
    int2float_pipe #(.EXP_W(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]), .in_data(in_data),
        .out_valid(vld[3]), .out_ready(out_ready), .out_sign(sg[3]), .out_exp(ex3),
        .out_man(mn[3]), .out_inexact(ix[3]), .out_ovf(ov[3])
    );

    // Value-level reference: value = q * 2^(e-3) with q in [8,16), exponent field e-2.
    function automatic res_t model(input logic [10:0] d, input int k);
        res_t r;
        int   v, e, scale, q, rem, xe, emax;
        bit   sgn, rne;
        sgn  = (k == 2);
        rne  = (k == 0) || (k == 2);
        emax = (k == 3) ? 7 : 15;
        r    = '0;
        v    = int'(d);
        if (sgn && v >= 1024) begin
            v   = 2048 - v;
            r.s = 1'b1;
        end
        if (v < 8) begin
            r.m = 3'(v);
            return r;
        end
        e = 3;
        while ((2 << e) <= v) e++;
        scale = 1 << (e - 3);
        q     = v / scale;
        rem   = v % scale;
        r.ix  = (rem != 0);
        if (rne && ((2 * rem > scale) || ((2 * rem == scale) && (q % 2 == 1)))) q++;
        xe = e - 2;
        if (q == 16) begin
            q = 8;
            xe++;
        end
        if (xe > emax) begin
            r.e  = 4'(emax);
            r.m  = 3'd7;
            r.ov = 1'b1;
        end else begin
            r.e = 4'(xe);
            r.m = 3'(q - 8);
        end
        return r;
    endfunction

    function automatic res_t obs(input int k);
        res_t r;
        r.s  = sg[k];
        r.e  = (k == 3) ? {1'b0, ex3} : ex[k];
        r.m  = mn[k];
        r.ix = ix[k];
        r.ov = ov[k];
        return r;
    endfunction

    function automatic logic [10:0] rnd_word();
        logic [10:0] w;
        case ($urandom % 4)
            0: w = 11'($urandom % 32);
            1: begin
                w = 11'd1 << ($urandom % 11);
                w = w + 11'($urandom % 3) - 11'd1;
            end
            default: w = 11'($urandom);
        endcase
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One clock: score at the falling edge, return just after the rising edge.
    task automatic step();
        item_t it;
        @(negedge clk);
        cyc++;
        acc = in_valid && rdy[0];
        if (vld[0] && out_ready) begin
            chk("out_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                it = sbq.pop_front();
                popped++;
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("u%0d_res d=%h", k, it.d), 32'(obs(k)), 32'(model(it.d, k)));
                end
                if (lat_chk) chk($sformatf("latency d=%h", it.d), 32'(cyc - it.c), 32'd3);
            end
        end
        if (acc) sbq.push_back('{d: in_data, c: cyc});
        @(posedge clk);
        #1;
    endtask

    logic [10:0] dir_w [11] = '{11'd0, 11'd5, 11'd8, 11'd17, 11'd19, 11'd1000, 11'd2047,
                                11'h7F8, 11'h400, 11'h3FF, 11'd127};
    logic [10:0] bp_w  [6]  = '{11'd300, 11'd77, 11'd1500, 11'd9, 11'd2000, 11'd640};

    initial begin
        int idx, n, p0;

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("rst_valid u%0d", k), 32'(vld[k]), 32'd0);
        chk("rst_outputs u0", 32'(obs(0)), 32'd0);
        chk("rst_outputs u3", 32'(obs(3)), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(rdy[0]), 32'd1);
        chk("post_rst_out_valid", 32'(vld[0]), 32'd0);

        // Directed stream, back-to-back, fixed latency.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        p0        = popped;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = dir_w[i];
            step();
            chk($sformatf("stream_accept %0d", i), 32'(acc), 32'd1);
        end
        in_valid = 1'b0;
        repeat (5) step();
        chk("stream_count", 32'(popped - p0), 32'd11);
        lat_chk = 1'b0;

        // Backpressure: three words fill the pipe and the head must hold.
        out_ready = 1'b0;
        idx       = 0;
        p0        = popped;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = bp_w[idx];
            step();
            if (acc) idx++;
            if (i >= 2) begin
                chk($sformatf("bp_hold_valid %0d", i), 32'(vld[0]), 32'd1);
                chk($sformatf("bp_hold_res %0d", i), 32'(obs(0)), 32'(model(bp_w[0], 0)));
            end
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_in_ready", 32'(rdy[0]), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && idx < 6; i++) begin
            in_data = bp_w[idx];
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("bp_all_accepted", 32'(idx), 32'd6);
        chk("bp_count", 32'(popped - p0), 32'd6);

        // Random valid/ready traffic.
        n  = 0;
        p0 = popped;
        for (int i = 0; i < 60000 && n < 10000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = rnd_word();
            out_ready = ($urandom % 8) < 6;
            step();
            if (acc) n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("rand_words", 32'(n), 32'd10000);
        chk("rand_count", 32'(popped - p0), 32'(n));
        chk("rand_drained", 32'(sbq.size()), 32'd0);

        // Asynchronous reset with three words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 11'(i + 1);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(vld[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(vld[0]), 32'd0);
        chk("async_rst_outputs", 32'(obs(0)), 32'd0);
        chk("async_rst_in_ready", 32'(rdy[0]), 32'd1);
        sbq.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        p0        = popped;
        in_valid  = 1'b1;
        in_data   = 11'h555;
        step();
        chk("post_rst_accept", 32'(acc), 32'd1);
        in_valid = 1'b0;
        repeat (5) step();
        chk("post_rst_count", 32'(popped - p0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
